// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch entry type and default queue depth
package fetch_queue_pkg;

    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// fetch_queue_storage: DEPTH-entry register file, one sync write port, one async read port, no reset
module fetch_queue_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t mem_q [DEPTH];

    // write the addressed entry on a qualified push
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch-to-decode buffer with valid/ready handshake and flush.
// Optional same-cycle bypass on an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, byp, push, pop, store;
    fetch_entry_t  rdata;

    // handshake decode; in_ready deliberately ignores out_ready
    always_comb begin
        full      = count_q == CW'(DEPTH);
        empty     = count_q == '0;
        in_ready  = !flush && !full;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp       = empty && in_valid && !flush;
`else
        byp       = 1'b0;
`endif
        out_valid = !flush && (!empty || byp);
        out_pc    = byp ? in_pc : rdata.pc;
        out_instr = byp ? in_instr : rdata.instr;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready && !empty;
        store     = push && !(byp && out_ready);
    end

    // next pointers and occupancy; flush overrides any push or pop
    always_comb begin
        wptr_d  = wptr_q + AW'(store);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(store) - CW'(pop);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    fetch_queue_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (clk),
        .we    (store),
        .waddr (wptr_q),
        .wdata ('{pc: in_pc, instr: in_instr}),
        .raddr (rptr_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and random traffic against a queue model
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];

    typedef struct {
        bit          f, iv;
        logic [31:0] pc, instr;
        bit          ordy;
        bit          ir, ov;
        logic [31:0] epc, einstr;
        int          cnt;
    } vec_t;

    vec_t tv[10];

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // drive inputs just after a rising edge, then move to the falling edge for checks
    task automatic drive(input bit f, input bit iv, input logic [31:0] pc, input logic [31:0] instr, input bit ordy);
        flush = f;
        in_valid = iv;
        in_pc = pc;
        in_instr = instr;
        out_ready = ordy;
        @(negedge clk);
    endtask

    // advance the reference queue by the rules of one clock edge, then step the clock
    task automatic commit();
        bit ir, ov;
        ent_t e;
        ir = !flush && q.size() != 4;
        ov = !flush && q.size() != 0;
        if (flush) q.delete();
        else begin
            if (ov && out_ready) void'(q.pop_front());
            if (in_valid && ir) begin
                e.pc = in_pc;
                e.instr = in_instr;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit ir, ov;
        ir = !flush && q.size() != 4;
        ov = !flush && q.size() != 0;
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
        if (ov) begin
            chk({tag, "_out_pc"}, out_pc, q[0].pc);
            chk({tag, "_out_instr"}, out_instr, q[0].instr);
        end
    endtask

    task automatic idle_drain();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 1);
            commit();
        end
    endtask

    initial begin
        tv[0] = '{0, 1, 32'h0,  32'h13, 0, 1, 0, 32'h0, 32'h0,  0};
        tv[1] = '{0, 1, 32'h4,  32'h14, 0, 1, 1, 32'h0, 32'h13, 1};
        tv[2] = '{0, 1, 32'h8,  32'h15, 0, 1, 1, 32'h0, 32'h13, 2};
        tv[3] = '{0, 1, 32'hC,  32'h16, 0, 1, 1, 32'h0, 32'h13, 3};
        tv[4] = '{0, 1, 32'h10, 32'h17, 0, 0, 1, 32'h0, 32'h13, 4};
        tv[5] = '{0, 0, 32'h0,  32'h0,  1, 0, 1, 32'h0, 32'h13, 4};
        tv[6] = '{0, 0, 32'h0,  32'h0,  1, 1, 1, 32'h4, 32'h14, 3};
        tv[7] = '{0, 0, 32'h0,  32'h0,  1, 1, 1, 32'h8, 32'h15, 2};
        tv[8] = '{0, 0, 32'h0,  32'h0,  1, 1, 1, 32'hC, 32'h16, 1};
        tv[9] = '{0, 0, 32'h0,  32'h0,  0, 1, 0, 32'h0, 32'h0,  0};

        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_count", 32'(count), 0);
        chk("idle_out_valid", 32'(out_valid), 0);
        commit();

        for (int i = 0; i < 10; i++) begin
            drive(tv[i].f, tv[i].iv, tv[i].pc, tv[i].instr, tv[i].ordy);
            chk($sformatf("tv%0d_in_ready", i), 32'(in_ready), 32'(tv[i].ir));
            chk($sformatf("tv%0d_out_valid", i), 32'(out_valid), 32'(tv[i].ov));
            chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].cnt));
            if (tv[i].ov) begin
                chk($sformatf("tv%0d_out_pc", i), out_pc, tv[i].epc);
                chk($sformatf("tv%0d_out_instr", i), out_instr, tv[i].einstr);
            end
            commit();
        end

        for (int k = 0; k <= 20; k++) begin
            drive(0, k < 20, 32'(4 * k), 32'h1000 + 32'(k), 1);
            if (k == 0) chk("stream_count0", 32'(count), 0);
            else begin
                chk($sformatf("stream%0d_count", k), 32'(count), 1);
                chk($sformatf("stream%0d_out_valid", k), 32'(out_valid), 1);
                chk($sformatf("stream%0d_out_pc", k), out_pc, 32'(4 * (k - 1)));
                chk($sformatf("stream%0d_out_instr", k), out_instr, 32'h1000 + 32'(k - 1));
            end
            commit();
        end
        drive(0, 0, 0, 0, 0);
        chk("stream_end_count", 32'(count), 0);
        commit();

        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h200 + 32'(4 * i), 32'h2000 + 32'(i), 0);
            commit();
        end
        drive(1, 1, 32'h20, 32'h20, 1);
        chk("flush_in_ready", 32'(in_ready), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_count_before", 32'(count), 3);
        commit();
        drive(0, 1, 32'h100, 32'h100, 0);
        chk("post_flush_count", 32'(count), 0);
        chk("post_flush_out_valid", 32'(out_valid), 0);
        commit();
        drive(0, 0, 0, 0, 1);
        chk("post_flush_head_pc", out_pc, 32'h100);
        chk("post_flush_head_valid", 32'(out_valid), 1);
        commit();
        idle_drain();

        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h300 + 32'(4 * i), 32'h3000 + 32'(i), 0);
            commit();
        end
        drive(0, 1, 32'h400, 32'h4000, 1);
        chk("fullpop_in_ready", 32'(in_ready), 0);
        chk("fullpop_out_pc", out_pc, 32'h300);
        chk("fullpop_count", 32'(count), 4);
        commit();
        drive(0, 0, 0, 0, 0);
        chk("fullpop_next_count", 32'(count), 3);
        chk("fullpop_next_in_ready", 32'(in_ready), 1);
        chk("fullpop_next_out_pc", out_pc, 32'h304);
        commit();
        idle_drain();

        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h500 + 32'(4 * i), 32'h5000 + 32'(i), 0);
            commit();
        end
        drive(0, 0, 0, 0, 0);
        chk("midrst_count_before", 32'(count), 3);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 2) == 0);
            check_model($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_count_le4", i), 32'(count <= 3'd4), 1);
            commit();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between instruction fetch and decode. Captures each fetched {PC, instruction} pair from `ProgramCounter`/`InstructionMemory`, holds up to DEPTH entries in order, and presents them to decode under a valid/ready handshake. Its `in_ready` is the PC advance enable, so decode stalls back-pressure fetch. `flush` discards all buffered entries when a jump or branch redirects `PCNext`.

## Interface
- DEPTH, default 4: number of entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  discard all entries; sampled at clk edge.
- in_valid  in  1  fetch presents a valid pair this cycle.
- in_pc  in  32  address of fetched instruction.
- in_instr  in  32  fetched instruction word.
- in_ready  out  1  queue accepts a push this cycle; drives PC write enable.
- out_valid  out  1  head entry valid for decode.
- out_pc  out  32  head entry PC.
- out_instr  out  32  head entry instruction.
- out_ready  in  1  decode consumes head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer, write pointer `wptr`, read pointer `rptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy held in `count`.
- Push: `in_valid && in_ready && !flush` writes entry at `wptr`, `wptr` increments.
- Pop: `out_valid && out_ready && !flush` increments `rptr`.
- `in_ready = !flush && (count != DEPTH)`; it does not depend on `out_ready`, so a full queue refuses a push even when a pop occurs in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both happen, and count is unchanged.
- `out_valid = !flush && (count != 0)` without the bypass option. `out_pc` and `out_instr` come from entry `rptr`; their value is don't-care when `out_valid` = 0.
- Flush has priority over everything. In the flush cycle, `in_ready` = 0 and `out_valid` = 0. At the next edge, `count` = 0 and `rptr` = `wptr` = 0. Neither a push nor a pop is counted in the flush cycle.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush or reset.

## Timing
- Reset (asynchronous, any time, including mid-transfer): `count` = 0, `rptr` = `wptr` = 0, `out_valid` = 0, `in_ready` = 1 once reset deasserts. Storage contents are not reset.
- Latency without bypass: an entry pushed at edge N is visible with `out_valid` = 1 from cycle N+1.
- Throughput: one push and one pop per cycle in steady state.
- Full: `in_ready` falls in the same cycle that `count` reaches DEPTH, and rises the cycle after the first pop.
- Empty: `out_valid` = 0 at `count` = 0; a pop request is ignored.
- All outputs are combinational from registers and `flush`. There is no path from `out_ready` to `in_ready`.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `count` = 0, `in_valid` = 1 and `!flush`, the input pair appears on the outputs in the same cycle with `out_valid` = 1.
  - If `out_ready` = 1 in that cycle, the pair is consumed directly and not stored; `count` stays 0.
  - Otherwise it is stored normally.
  - Latency is 0 cycles on an empty queue.
- Not defined: no combinational in-to-out path; minimum latency is 1 cycle. `out_valid` is exactly `!flush && count != 0`.

## Structure
- `Pkg` gains `fetch_entry_t`, a packed struct {pc[31:0], instr[31:0]}, shared with the decode stage.
- `Pkg` gains localparam `FETCH_QUEUE_DEPTH` = 4, the default for DEPTH.
- One sub-module, `fetch_queue_storage`: DEPTH×`fetch_entry_t` register array with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`), no reset.
- Pointer, count, handshake and flush logic live in `fetch_queue`.

## Test plan
- Reset then idle: `count` = 0, `out_valid` = 0, `in_ready` = 1; assert reset mid-stream with `count` = 3 and check `count` = 0 and `out_valid` = 0 immediately.
- Fill without pops, DEPTH=4: push PCs 0x0, 0x4, 0x8, 0xC with instrs 0x00000013..0x00000016. Check `in_ready` = 0 after the 4th push, and that a 5th push (PC 0x10) is not accepted. Then pop 4 and check order 0x0, 0x4, 0x8, 0xC and matching instrs.
- Continuous streaming, 20 pushes of PC 0x0..0x4C with `out_ready` = 1: all 20 appear in order at 1 per cycle; `count` stays at 1 without bypass and 0 with bypass.
- Flush with `count` = 3 and `in_valid` = 1 (PC 0x20): in the flush cycle `in_ready` = 0 and `out_valid` = 0; next cycle `count` = 0; the next push, PC 0x100, is the next output.
- Full and pop simultaneously with `in_valid` = 1: the pop occurs, the push is refused, `count` goes 4 → 3, and `in_ready` = 1 the next cycle.
- Wrap-around: 10 pushes interleaved with random `out_ready` stalls; outputs match a reference FIFO model and `count` never exceeds 4.
